// File: rtl/pong_pkg.sv
// Shared Pong definitions: match FSM encoding, score width and playfield size.
package pong_pkg;

    localparam int unsigned c_SCORE_LIMIT = 9;
    localparam int unsigned c_SCORE_W     = 4;
    localparam int unsigned c_GAME_WIDTH  = 40;
    localparam int unsigned c_GAME_HEIGHT = 30;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SERVE_WAIT = 3'd1,
        RUNNING    = 3'd2,
        POINT      = 3'd3,
        MATCH_OVER = 3'd4
    } state_t;

endpackage

// File: rtl/pong_edge_det.sv
// Rising-edge detector: one-cycle pulse when a level input goes from low to high.
module pong_edge_det (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Level,
    output logic o_Rise_c
);

    logic level_q;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= i_Level;
        end
    end

    assign o_Rise_c = i_Level & ~level_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve countdown, rally, point award and first-to-limit win.
// Define PONG_SPEED_RAMP_EN to shorten the ball step period on every paddle hit.
module pong_match_ctrl #(
    parameter int unsigned c_SCORE_LIMIT    = pong_pkg::c_SCORE_LIMIT,
    parameter int unsigned c_SERVE_FRAMES   = 60,
    parameter int unsigned c_BALL_SPEED     = 1250000,
    parameter int unsigned c_BALL_SPEED_MIN = 416667,
    parameter int unsigned c_SPEED_STEP     = 104166
) (
    input  logic                                i_Clk,
    input  logic                                i_Rst,
    input  logic                                i_Game_Start,
    input  logic                                i_Frame_Tick,
    input  logic                                i_P1_Miss,
    input  logic                                i_P2_Miss,
    input  logic                                i_Paddle_Hit,
    output logic                                o_Game_Active,
    output logic                                o_Serve_P2,
    output logic [pong_pkg::c_SCORE_W-1:0]      o_P1_Score,
    output logic [pong_pkg::c_SCORE_W-1:0]      o_P2_Score,
    output logic                                o_Match_Over,
    output logic                                o_Winner_P2,
    output logic [$clog2(c_BALL_SPEED+1)-1:0]   o_Ball_Speed
);

    localparam int unsigned SCORE_W = pong_pkg::c_SCORE_W;
    localparam int unsigned SPEED_W = $clog2(c_BALL_SPEED + 1);
    localparam int unsigned FRAME_W = $clog2(c_SERVE_FRAMES + 1);

    pong_pkg::state_t     state_q, state_d;
    logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [SCORE_W-1:0]   p1_score_q, p1_score_d;
    logic [SCORE_W-1:0]   p2_score_q, p2_score_d;
    logic [SPEED_W-1:0]   speed_q, speed_d;
    logic                 serve_p2_q, serve_p2_d;
    logic                 winner_p2_q, winner_p2_d;
    logic                 award_p2_q, award_p2_d;
    logic                 game_active_q;
    logic                 match_over_q;
    logic                 start_rise_c;
    logic [SCORE_W-1:0]   new_score_c;

    pong_edge_det u_start_edge (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Level  (i_Game_Start),
        .o_Rise_c (start_rise_c)
    );

    // Score the awarded player would reach when POINT resolves
    assign new_score_c = (award_p2_q ? p2_score_q : p1_score_q) + SCORE_W'(1);

`ifndef PONG_SPEED_RAMP_EN
    logic unused_c;
    assign unused_c = ^{i_Paddle_Hit, 32'(c_BALL_SPEED_MIN), 32'(c_SPEED_STEP)};
`endif

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q       <= pong_pkg::IDLE;
            frame_cnt_q   <= '0;
            p1_score_q    <= '0;
            p2_score_q    <= '0;
            speed_q       <= SPEED_W'(c_BALL_SPEED);
            serve_p2_q    <= 1'b0;
            winner_p2_q   <= 1'b0;
            award_p2_q    <= 1'b0;
            game_active_q <= 1'b0;
            match_over_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            p1_score_q    <= p1_score_d;
            p2_score_q    <= p2_score_d;
            speed_q       <= speed_d;
            serve_p2_q    <= serve_p2_d;
            winner_p2_q   <= winner_p2_d;
            award_p2_q    <= award_p2_d;
            game_active_q <= (state_d == pong_pkg::RUNNING);
            match_over_q  <= (state_d == pong_pkg::MATCH_OVER);
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        speed_d     = speed_q;
        serve_p2_d  = serve_p2_q;
        winner_p2_d = winner_p2_q;
        award_p2_d  = award_p2_q;

        unique case (state_q)
            pong_pkg::IDLE: begin
                if (start_rise_c) begin
                    state_d     = pong_pkg::SERVE_WAIT;
                    frame_cnt_d = '0;
                    speed_d     = SPEED_W'(c_BALL_SPEED);
                end
            end
            pong_pkg::SERVE_WAIT: begin
                if (i_Frame_Tick) begin
                    frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                    if (frame_cnt_q == FRAME_W'(c_SERVE_FRAMES - 1)) begin
                        state_d = pong_pkg::RUNNING;
                    end
                end
            end
            pong_pkg::RUNNING: begin
`ifdef PONG_SPEED_RAMP_EN
                if (i_Paddle_Hit) begin
                    if (32'(speed_q) >= c_BALL_SPEED_MIN + c_SPEED_STEP) begin
                        speed_d = speed_q - SPEED_W'(c_SPEED_STEP);
                    end else begin
                        speed_d = SPEED_W'(c_BALL_SPEED_MIN);
                    end
                end
`endif
                // A simultaneous double miss is a let: re-serve with no score change
                if (i_P1_Miss && i_P2_Miss) begin
                    state_d     = pong_pkg::SERVE_WAIT;
                    frame_cnt_d = '0;
                    speed_d     = SPEED_W'(c_BALL_SPEED);
                end else if (i_P1_Miss) begin
                    state_d    = pong_pkg::POINT;
                    award_p2_d = 1'b1;
                end else if (i_P2_Miss) begin
                    state_d    = pong_pkg::POINT;
                    award_p2_d = 1'b0;
                end
            end
            pong_pkg::POINT: begin
                if (award_p2_q) begin
                    p2_score_d = new_score_c;
                    serve_p2_d = 1'b0;
                end else begin
                    p1_score_d = new_score_c;
                    serve_p2_d = 1'b1;
                end
                if (new_score_c == SCORE_W'(c_SCORE_LIMIT)) begin
                    state_d     = pong_pkg::MATCH_OVER;
                    winner_p2_d = award_p2_q;
                end else begin
                    state_d     = pong_pkg::SERVE_WAIT;
                    frame_cnt_d = '0;
                    speed_d     = SPEED_W'(c_BALL_SPEED);
                end
            end
            pong_pkg::MATCH_OVER: begin
                if (start_rise_c) begin
                    state_d     = pong_pkg::SERVE_WAIT;
                    p1_score_d  = '0;
                    p2_score_d  = '0;
                    serve_p2_d  = 1'b0;
                    frame_cnt_d = '0;
                    speed_d     = SPEED_W'(c_BALL_SPEED);
                end
            end
            default: begin
                state_d = pong_pkg::IDLE;
            end
        endcase
    end

    assign o_Game_Active = game_active_q;
    assign o_Serve_P2    = serve_p2_q;
    assign o_P1_Score    = p1_score_q;
    assign o_P2_Score    = p2_score_q;
    assign o_Match_Over  = match_over_q;
    assign o_Winner_P2   = winner_p2_q;
    assign o_Ball_Speed  = speed_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with a cycle-level match model and literal spot checks.
module tb_pong_match_ctrl;

    localparam int LIMIT  = 9;
    localparam int FRAMES = 60;
    localparam int SPEED  = 1250000;
    localparam int SMIN   = 416667;
    localparam int STEP   = 104166;
    localparam int SPW    = $clog2(SPEED + 1);
`ifdef PONG_SPEED_RAMP_EN
    localparam int RAMP_EXP = 416667;
`else
    localparam int RAMP_EXP = 1250000;
`endif

    logic           i_Clk = 1'b0;
    logic           i_Rst = 1'b0;
    logic           i_Game_Start = 1'b0;
    logic           i_Frame_Tick = 1'b0;
    logic           i_P1_Miss = 1'b0;
    logic           i_P2_Miss = 1'b0;
    logic           i_Paddle_Hit = 1'b0;
    logic           o_Game_Active;
    logic           o_Serve_P2;
    logic [3:0]     o_P1_Score;
    logic [3:0]     o_P2_Score;
    logic           o_Match_Over;
    logic           o_Winner_P2;
    logic [SPW-1:0] o_Ball_Speed;

    int n_checks = 0;
    int n_fail   = 0;

    pong_match_ctrl dut (
        .i_Clk         (i_Clk),
        .i_Rst         (i_Rst),
        .i_Game_Start  (i_Game_Start),
        .i_Frame_Tick  (i_Frame_Tick),
        .i_P1_Miss     (i_P1_Miss),
        .i_P2_Miss     (i_P2_Miss),
        .i_Paddle_Hit  (i_Paddle_Hit),
        .o_Game_Active (o_Game_Active),
        .o_Serve_P2    (o_Serve_P2),
        .o_P1_Score    (o_P1_Score),
        .o_P2_Score    (o_P2_Score),
        .o_Match_Over  (o_Match_Over),
        .o_Winner_P2   (o_Winner_P2),
        .o_Ball_Speed  (o_Ball_Speed)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Match model: phases of play described from the rules, advanced once per clock
    typedef enum {M_LOBBY, M_COUNTDOWN, M_PLAY, M_AWARD, M_DONE} phase_t;
    phase_t m_phase;
    int     m_ticks, m_p1, m_p2, m_speed;
    bit     m_to_p2, m_serve, m_win, m_active, m_over, m_prev_start, m_rise;

    task automatic m_new_serve();
        m_phase = M_COUNTDOWN;
        m_ticks = 0;
        m_speed = SPEED;
    endtask

    always @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            m_phase = M_LOBBY; m_ticks = 0; m_p1 = 0; m_p2 = 0; m_speed = SPEED;
            m_to_p2 = 0; m_serve = 0; m_win = 0; m_active = 0; m_over = 0; m_prev_start = 0;
        end else begin
            m_rise = i_Game_Start && !m_prev_start;
            m_prev_start = i_Game_Start;
            case (m_phase)
                M_LOBBY: if (m_rise) m_new_serve();
                M_COUNTDOWN: if (i_Frame_Tick) begin
                    m_ticks++;
                    if (m_ticks == FRAMES) m_phase = M_PLAY;
                end
                M_PLAY: begin
`ifdef PONG_SPEED_RAMP_EN
                    if (i_Paddle_Hit) m_speed = (m_speed - STEP < SMIN) ? SMIN : m_speed - STEP;
`endif
                    if (i_P1_Miss && i_P2_Miss) m_new_serve();
                    else if (i_P1_Miss) begin m_phase = M_AWARD; m_to_p2 = 1; end
                    else if (i_P2_Miss) begin m_phase = M_AWARD; m_to_p2 = 0; end
                end
                M_AWARD: begin
                    if (m_to_p2) begin m_p2++; m_serve = 0; end
                    else begin m_p1++; m_serve = 1; end
                    if (m_p1 == LIMIT || m_p2 == LIMIT) begin
                        m_phase = M_DONE;
                        m_win = m_to_p2;
                    end else m_new_serve();
                end
                M_DONE: if (m_rise) begin
                    m_p1 = 0; m_p2 = 0; m_serve = 0;
                    m_new_serve();
                end
                default: m_phase = M_LOBBY;
            endcase
            m_active = (m_phase == M_PLAY);
            m_over   = (m_phase == M_DONE);
        end
    end

    // Every-cycle comparison against the model
    always @(negedge i_Clk) begin
        if (!i_Rst) begin
            chk("game_active", 32'(o_Game_Active), 32'(m_active));
            chk("serve_p2",    32'(o_Serve_P2),    32'(m_serve));
            chk("p1_score",    32'(o_P1_Score),    32'(m_p1));
            chk("p2_score",    32'(o_P2_Score),    32'(m_p2));
            chk("match_over",  32'(o_Match_Over),  32'(m_over));
            chk("ball_speed",  32'(o_Ball_Speed),  32'(m_speed));
            if (m_over) chk("winner_p2", 32'(o_Winner_P2), 32'(m_win));
        end
    end

    task automatic drive(input logic tk, input logic m1, input logic m2, input logic hit);
        i_Frame_Tick = tk; i_P1_Miss = m1; i_P2_Miss = m2; i_Paddle_Hit = hit;
        @(negedge i_Clk);
    endtask

    task automatic serve();
        for (int i = 0; i < FRAMES; i++) begin
            drive(1, 0, 0, 0);
            drive(0, 0, 0, 0);
        end
    endtask

    task automatic point(input logic m1, input logic m2);
        drive(0, m1, m2, 0);
        drive(0, 0, 0, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_active"}, 32'(o_Game_Active), 0);
        chk({tag, "_serve"},  32'(o_Serve_P2),    0);
        chk({tag, "_p1"},     32'(o_P1_Score),    0);
        chk({tag, "_p2"},     32'(o_P2_Score),    0);
        chk({tag, "_over"},   32'(o_Match_Over),  0);
        chk({tag, "_winner"}, 32'(o_Winner_P2),   0);
        chk({tag, "_speed"},  32'(o_Ball_Speed),  SPEED);
    endtask

    initial begin
        #1 i_Rst = 1'b1;
        #2 chk_reset_vals("reset");
        @(negedge i_Clk); #1 i_Rst = 1'b0;
        @(negedge i_Clk);
        drive(0, 0, 0, 0);

        // Start edge, then exactly 60 ticks before release; start held high meanwhile
        i_Game_Start = 1'b1;
        drive(0, 1, 0, 0);
        for (int i = 0; i < FRAMES; i++) begin
            drive(1, 0, 0, 0);
            if (i == FRAMES - 2) chk("active_before_tick60", 32'(o_Game_Active), 0);
            if (i == FRAMES - 1) chk("active_after_tick60", 32'(o_Game_Active), 1);
            if (i < FRAMES - 1) drive(0, 0, 0, 0);
        end
        i_Game_Start = 1'b0;

        // Ten paddle hits, then P1 misses
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 1);
            drive(0, 0, 0, 0);
        end
        chk("speed_after_10_hits", 32'(o_Ball_Speed), RAMP_EXP);
        drive(0, 1, 0, 0);
        chk("active_drop_after_miss", 32'(o_Game_Active), 0);
        drive(0, 0, 0, 0);
        chk("p2_score_1", 32'(o_P2_Score), 1);
        chk("serve_toward_p2", 32'(o_Serve_P2), 0);
        chk("speed_reload", 32'(o_Ball_Speed), SPEED);

        // Let: both miss together
        serve();
        drive(0, 1, 1, 1);
        chk("let_active", 32'(o_Game_Active), 0);
        chk("let_p1", 32'(o_P1_Score), 0);
        chk("let_p2", 32'(o_P2_Score), 1);
        drive(0, 0, 0, 0);

        // P1 wins on nine P2 misses
        for (int k = 0; k < LIMIT; k++) begin
            serve();
            point(0, 1);
            if (k == 0) chk("serve_toward_p1", 32'(o_Serve_P2), 1);
        end
        chk("p1_win_score", 32'(o_P1_Score), 9);
        chk("p1_win_over", 32'(o_Match_Over), 1);
        chk("p1_win_winner", 32'(o_Winner_P2), 0);
        drive(0, 1, 0, 1);
        drive(0, 0, 1, 0);
        chk("over_holds_p1", 32'(o_P1_Score), 9);
        i_Game_Start = 1'b1;
        drive(0, 0, 0, 0);
        chk("restart_p1", 32'(o_P1_Score), 0);
        chk("restart_p2", 32'(o_P2_Score), 0);
        chk("restart_over", 32'(o_Match_Over), 0);
        i_Game_Start = 1'b0;

        // P2 wins; start raised mid-rally must not restart the finished match
        for (int k = 0; k < LIMIT; k++) begin
            serve();
            if (k == LIMIT - 1) i_Game_Start = 1'b1;
            point(1, 0);
        end
        chk("p2_win_score", 32'(o_P2_Score), 9);
        chk("p2_win_winner", 32'(o_Winner_P2), 1);
        chk("p2_win_serve", 32'(o_Serve_P2), 0);
        repeat (3) drive(0, 0, 0, 0);
        chk("held_start_no_retrigger", 32'(o_Match_Over), 1);
        i_Game_Start = 1'b0;
        drive(0, 0, 0, 0);
        i_Game_Start = 1'b1;
        drive(0, 0, 0, 0);
        chk("restart2_over", 32'(o_Match_Over), 0);
        i_Game_Start = 1'b0;

        // Build 3:5, then reset during a rally
        for (int k = 0; k < 3; k++) begin serve(); point(0, 1); end
        for (int k = 0; k < 5; k++) begin serve(); point(1, 0); end
        serve();
        drive(0, 0, 0, 1);
        chk("pre_reset_p1", 32'(o_P1_Score), 3);
        chk("pre_reset_p2", 32'(o_P2_Score), 5);
        chk("pre_reset_active", 32'(o_Game_Active), 1);
        #2 i_Rst = 1'b1;
        #1 chk_reset_vals("midgame_reset");
        @(negedge i_Clk); #1 i_Rst = 1'b0;
        @(negedge i_Clk);
        i_Game_Start = 1'b1;
        drive(0, 0, 0, 0);
        i_Game_Start = 1'b0;
        serve();
        chk("post_reset_active", 32'(o_Game_Active), 1);
        point(0, 1);
        chk("post_reset_p1", 32'(o_P1_Score), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
